regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-read-port register file with asynchronous active-low reset, same-cycle write-to-read bypass, a per-register busy scoreboard, and a handshaked sequential dump port. It sits in the NPC decode/writeback path in place of the single-port register file. The dump port streams architectural state to the simulation harness one register per accepted beat, so no combinational export of the whole array is needed.

## Interface
- ADDR_WIDTH, 5, register index width; depth = 2**ADDR_WIDTH
- DATA_WIDTH, 32, register width
- NR_READ, 2, number of read ports (≥1)
- BYPASS, 1, 1 = write data forwarded to same-cycle reads; 0 = read returns stored value
- ZERO_REG, 1, 1 = index 0 hardwired to zero and never busy

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wen  in  1  writeback enable
- waddr  in  ADDR_WIDTH  writeback index
- wdata  in  DATA_WIDTH  writeback data
- raddr  in  NR_READ*ADDR_WIDTH  read indices; port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
- rdata  out  NR_READ*DATA_WIDTH  read data, same packing
- rs_busy  out  NR_READ  per-port scoreboard busy flag for raddr port i
- iss_valid  in  1  issue of an instruction with a destination register
- iss_rd  in  ADDR_WIDTH  destination index to mark busy
- dump_req  in  1  start a full-array dump (sampled in IDLE only)
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  harness accepts beat
- dump_idx  out  ADDR_WIDTH  index of current beat
- dump_data  out  DATA_WIDTH  stored value of register dump_idx
- dump_done  out  1  one-cycle pulse after last beat accepted

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH flops; reset clears all entries to 0.
- Write: on clk edge with wen=1, rf[waddr] <= wdata; if ZERO_REG and waddr=0, write dropped.
- Read (combinational, per port i): if ZERO_REG and raddr_i=0 -> 0; else if BYPASS and wen and waddr=raddr_i -> wdata; else rf[raddr_i]. No bypass from a write to index 0 when ZERO_REG.
- Scoreboard: busy bit per index, reset 0. Edge with iss_valid sets busy[iss_rd]; edge with wen clears busy[waddr]. Same index set and clear in one cycle -> set wins (new producer). iss_rd=0 ignored when ZERO_REG.
- rs_busy[i] = busy[raddr_i], forced 0 when BYPASS and wen and waddr=raddr_i (value forwarded), and forced 0 for index 0 when ZERO_REG.
- Dump FSM states: IDLE, SCAN, DONE.
  - IDLE: dump_valid=0. dump_req=1 -> SCAN, counter=0.
  - SCAN: dump_valid=1, dump_idx=counter, dump_data=rf[counter] (stored value, no bypass; index 0 reads 0 when ZERO_REG). On dump_valid&dump_ready: if counter=2**ADDR_WIDTH-1 -> DONE, else counter+1. No ready -> hold idx and state; dump_data follows any write that lands on dump_idx while held.
  - DONE: dump_done=1 for exactly one cycle -> IDLE.
  - dump_req outside IDLE ignored; dump runs concurrently with normal reads/writes.
- Reset mid-dump: asynchronous return to IDLE, counter 0, all outputs to reset values; no dump_done.

## Timing
- Reset values: rdata = 0 on all ports (all entries 0), rs_busy=0, dump_valid=0, dump_idx=0, dump_data=0, dump_done=0.
- Read latency 0 cycles; write visible in storage the cycle after wen; visible same cycle via bypass when BYPASS=1.
- Busy visible on rs_busy the cycle after iss_valid; cleared the cycle after wen (same cycle when BYPASS=1).
- Dump with dump_ready held 1: first beat 1 cycle after dump_req, 2**ADDR_WIDTH consecutive beats, dump_done on the cycle after last beat, IDLE next; total 2**ADDR_WIDTH+2 cycles from dump_req to IDLE.

## Test plan
- Reset then read all indices on both ports -> rdata=0, rs_busy=0, dump_valid=0.
- wen=1, waddr=5, wdata=0xDEADBEEF, raddr0=5, raddr1=0 same cycle -> rdata0=0xDEADBEEF (BYPASS=1), rdata1=0; next cycle BYPASS=0 instance also reads 0xDEADBEEF; write to index 0 -> reads stay 0.
- iss_valid rd=7; next cycle raddr0=7 -> rs_busy0=1; wen waddr=7 with iss_valid rd=7 same cycle -> busy stays 1; lone wen waddr=7 -> rs_busy0=0 same cycle (BYPASS=1).
- Load rf[i]=i*3, dump_req, dump_ready=1 -> 32 beats idx 0..31, data 0,3,...,93 (idx0=0), dump_done one cycle, 34 cycles total.
- Dump with dump_ready toggling 1,0,0,1 -> idx holds during stall, no beat skipped or duplicated; write to held idx updates dump_data.
- Assert rst_n=0 at beat 10 of a dump -> dump_valid=0 immediately, no dump_done, all registers 0; fresh dump_req restarts at idx 0.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-read-port register file with write bypass, busy scoreboard and a
// handshaked sequential dump port that streams stored state one register per beat.
module regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wen,
    input  logic [ADDR_WIDTH-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0]         wdata,
    input  logic [NR_READ*ADDR_WIDTH-1:0] raddr,
    output logic [NR_READ*DATA_WIDTH-1:0] rdata,
    output logic [NR_READ-1:0]            rs_busy,
    input  logic                          iss_valid,
    input  logic [ADDR_WIDTH-1:0]         iss_rd,
    input  logic                          dump_req,
    output logic                          dump_valid,
    input  logic                          dump_ready,
    output logic [ADDR_WIDTH-1:0]         dump_idx,
    output logic [DATA_WIDTH-1:0]         dump_data,
    output logic                          dump_done
);

    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} dump_state_t;

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]      busy_q, busy_d;
    dump_state_t           state_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  valid_q, done_q;

    logic wr_en, iss_en;
    assign wr_en  = wen && !((ZERO_REG != 0) && (waddr == '0));
    assign iss_en = iss_valid && !((ZERO_REG != 0) && (iss_rd == '0));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rf_q[i] <= '0;
        end else if (wr_en) begin
            rf_q[waddr] <= wdata;
        end
    end

    // Clear first so a same-index issue re-marks the register for its new producer.
    always_comb begin
        busy_d = busy_q;
        if (wen)    busy_d[waddr]  = 1'b0;
        if (iss_en) busy_d[iss_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    for (genvar gi = 0; gi < NR_READ; gi++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic                  is_zero, fwd;
        assign ra      = raddr[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign is_zero = (ZERO_REG != 0) && (ra == '0);
        assign fwd     = (BYPASS != 0) && wen && (waddr == ra) && !is_zero;
        assign rdata[gi*DATA_WIDTH +: DATA_WIDTH] = is_zero ? '0 : (fwd ? wdata : rf_q[ra]);
        assign rs_busy[gi] = !is_zero && !fwd && busy_q[ra];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (dump_req) begin
                        state_q <= SCAN;
                        cnt_q   <= '0;
                        valid_q <= 1'b1;
                    end
                end
                SCAN: begin
                    if (dump_ready) begin
                        if (cnt_q == LAST_IDX) begin
                            state_q <= DONE;
                            cnt_q   <= '0;
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Dump reads the stored array directly so a held beat tracks landed writes.
    assign dump_valid = valid_q;
    assign dump_idx   = cnt_q;
    assign dump_done  = done_q;
    assign dump_data  = (!valid_q || ((ZERO_REG != 0) && (cnt_q == '0))) ? '0 : rf_q[cnt_q];

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a BYPASS=1 instance and a BYPASS=0 instance
// share stimulus; each task checks one feature against hand-computed values.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [9:0]  raddr;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        dump_req;
    logic        dump_ready;

    logic [63:0] rdata_b, rdata_n;
    logic [1:0]  busy_b, busy_n;
    logic        dv_b, dv_n, dd_b, dd_n;
    logic [4:0]  di_b, di_n;
    logic [31:0] dda_b, dda_n;

    logic [31:0] mem [32];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rs_busy(busy_b),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .dump_req(dump_req), .dump_valid(dv_b), .dump_ready(dump_ready),
        .dump_idx(di_b), .dump_data(dda_b), .dump_done(dd_b)
    );

    regfile_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .wen(wen), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rs_busy(busy_n),
        .iss_valid(iss_valid), .iss_rd(iss_rd),
        .dump_req(dump_req), .dump_valid(dv_n), .dump_ready(dump_ready),
        .dump_idx(di_n), .dump_data(dda_n), .dump_done(dd_n)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wen = 0; waddr = 0; wdata = 0; raddr = 0;
        iss_valid = 0; iss_rd = 0; dump_req = 0; dump_ready = 0;
        #12;
        for (int i = 0; i < 32; i++) begin
            raddr = {i[4:0], i[4:0]};
            #1;
            total++;
            if (rdata_b !== 64'h0 || rdata_n !== 64'h0) begin
                bad++; $display("FAIL reset_rdata idx=%0d got=%h/%h want=0", i, rdata_b, rdata_n);
            end
            total++;
            if (busy_b !== 2'b00 || busy_n !== 2'b00) begin
                bad++; $display("FAIL reset_busy idx=%0d got=%b/%b want=00", i, busy_b, busy_n);
            end
        end
        total++;
        if ({dv_b, dd_b, di_b, dda_b} !== 39'h0) begin
            bad++; $display("FAIL reset_dump got v=%b d=%b i=%0d data=%h want all 0", dv_b, dd_b, di_b, dda_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) mem[i] = 32'h0;
        step();
        $display("test_reset: checked 32 indices after reset");
    endtask

    task automatic test_write_bypass();
        wen = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd5};
        #1;
        total++;
        if (rdata_b !== {32'h0, 32'hDEADBEEF}) begin
            bad++; $display("FAIL bypass_same_cycle got=%h want=%h", rdata_b, {32'h0, 32'hDEADBEEF});
        end
        total++;
        if (rdata_n[31:0] !== 32'h0) begin
            bad++; $display("FAIL nobypass_same_cycle got=%h want=0", rdata_n[31:0]);
        end
        step();
        wen = 0;
        mem[5] = 32'hDEADBEEF;
        #1;
        total++;
        if (rdata_n[31:0] !== 32'hDEADBEEF || rdata_b[31:0] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL write_stored got=%h/%h want=deadbeef", rdata_b[31:0], rdata_n[31:0]);
        end
        wen = 1; waddr = 0; wdata = 32'hFFFFFFFF; raddr = {5'd0, 5'd0};
        #1;
        total++;
        if (rdata_b !== 64'h0 || rdata_n !== 64'h0) begin
            bad++; $display("FAIL zero_bypass got=%h/%h want=0", rdata_b, rdata_n);
        end
        step();
        wen = 0;
        #1;
        total++;
        if (rdata_b !== 64'h0 || rdata_n !== 64'h0) begin
            bad++; $display("FAIL zero_stored got=%h/%h want=0", rdata_b, rdata_n);
        end
        $display("test_write_bypass: wrote rf[5]=deadbeef, write to r0 dropped");
    endtask

    task automatic test_scoreboard();
        iss_valid = 1; iss_rd = 7; raddr = {5'd7, 5'd7};
        #1;
        total++;
        if (busy_b !== 2'b00) begin
            bad++; $display("FAIL busy_before_edge got=%b want=00", busy_b);
        end
        step();
        iss_valid = 0;
        #1;
        total++;
        if (busy_b !== 2'b11 || busy_n !== 2'b11) begin
            bad++; $display("FAIL busy_set got=%b/%b want=11", busy_b, busy_n);
        end
        wen = 1; waddr = 7; wdata = 32'h77; iss_valid = 1; iss_rd = 7;
        #1;
        total++;
        if (busy_b !== 2'b00 || busy_n !== 2'b11) begin
            bad++; $display("FAIL busy_fwd_mask got=%b/%b want=00/11", busy_b, busy_n);
        end
        step();
        wen = 0; iss_valid = 0;
        mem[7] = 32'h77;
        #1;
        total++;
        if (busy_b !== 2'b11 || busy_n !== 2'b11) begin
            bad++; $display("FAIL busy_set_wins got=%b/%b want=11", busy_b, busy_n);
        end
        wen = 1; waddr = 7; wdata = 32'h78;
        #1;
        total++;
        if (busy_b !== 2'b00 || busy_n !== 2'b11) begin
            bad++; $display("FAIL busy_clear_bypass got=%b/%b want=00/11", busy_b, busy_n);
        end
        step();
        wen = 0;
        mem[7] = 32'h78;
        #1;
        total++;
        if (busy_b !== 2'b00 || busy_n !== 2'b00) begin
            bad++; $display("FAIL busy_cleared got=%b/%b want=00", busy_b, busy_n);
        end
        $display("test_scoreboard: r7 busy set, set-wins, cleared");
    endtask

    task automatic load_triples();
        for (int i = 0; i < 32; i++) begin
            wen = 1; waddr = i[4:0]; wdata = i * 3;
            mem[i] = (i == 0) ? 32'h0 : i * 3;
            step();
        end
        wen = 0;
    endtask

    task automatic test_dump_full();
        load_triples();
        dump_req = 1; dump_ready = 1;
        step();
        dump_req = 0;
        for (int b = 0; b < 32; b++) begin
            #1;
            total++;
            if (dv_b !== 1'b1 || di_b !== b[4:0] || dda_b !== b * 3 || dd_b !== 1'b0) begin
                bad++; $display("FAIL dump_beat b=%0d got v=%b i=%0d d=%0d done=%b want v=1 i=%0d d=%0d done=0",
                                b, dv_b, di_b, dda_b, dd_b, b, b * 3);
            end
            step();
        end
        #1;
        total++;
        if (dv_b !== 1'b0 || dd_b !== 1'b1) begin
            bad++; $display("FAIL dump_done_pulse got v=%b done=%b want v=0 done=1", dv_b, dd_b);
        end
        step();
        #1;
        total++;
        if (dv_b !== 1'b0 || dd_b !== 1'b0) begin
            bad++; $display("FAIL dump_idle got v=%b done=%b want 0/0", dv_b, dd_b);
        end
        $display("test_dump_full: 32 beats then done pulse");
    endtask

    task automatic test_dump_stall();
        int  exp_idx;
        bit  wrote, finished;
        logic [31:0] held;
        exp_idx = 0; wrote = 0; finished = 0;
        dump_req = 1; dump_ready = 0;
        step();
        dump_req = 0;
        for (int c = 0; c < 200 && !finished; c++) begin
            dump_ready = (c % 4 == 0) || (c % 4 == 3);
            wen = 0;
            if (!dump_ready && exp_idx == 7 && !wrote) begin
                wen = 1; waddr = 7; wdata = 32'hA5A5A5A5; wrote = 1;
            end
            #1;
            total++;
            if (dv_b !== 1'b1 || di_b !== exp_idx[4:0] || dda_b !== mem[exp_idx]) begin
                bad++; $display("FAIL stall_beat c=%0d got v=%b i=%0d d=%h want v=1 i=%0d d=%h",
                                c, dv_b, di_b, dda_b, exp_idx, mem[exp_idx]);
            end
            step();
            if (wen) mem[waddr] = wdata;
            if (dump_ready) begin
                if (exp_idx == 31) finished = 1;
                else exp_idx++;
            end
        end
        wen = 0; dump_ready = 1;
        held = mem[7];
        total++;
        if (!finished || held !== 32'hA5A5A5A5) begin
            bad++; $display("FAIL stall_complete finished=%0d r7=%h want 1/a5a5a5a5", finished, held);
        end
        #1;
        total++;
        if (dd_b !== 1'b1) begin
            bad++; $display("FAIL stall_done got=%b want=1", dd_b);
        end
        step();
        $display("test_dump_stall: ready pattern 1,0,0,1 with write to held r7");
    endtask

    task automatic test_reset_mid_dump();
        dump_req = 1; dump_ready = 1;
        step();
        dump_req = 0;
        for (int b = 0; b < 10; b++) step();
        #1;
        total++;
        if (dv_b !== 1'b1 || di_b !== 5'd10) begin
            bad++; $display("FAIL mid_dump_pos got v=%b i=%0d want v=1 i=10", dv_b, di_b);
        end
        rst_n = 0; raddr = {5'd31, 5'd7};
        #1;
        total++;
        if (dv_b !== 1'b0 || di_b !== 5'd0 || dda_b !== 32'h0 || dd_b !== 1'b0) begin
            bad++; $display("FAIL async_reset_dump got v=%b i=%0d d=%h done=%b want 0", dv_b, di_b, dda_b, dd_b);
        end
        total++;
        if (rdata_b !== 64'h0 || rdata_n !== 64'h0) begin
            bad++; $display("FAIL async_reset_rf got=%h/%h want=0", rdata_b, rdata_n);
        end
        step();
        @(negedge clk);
        rst_n = 1;
        for (int c = 0; c < 4; c++) begin
            step();
            total++;
            if (dd_b !== 1'b0 || dv_b !== 1'b0) begin
                bad++; $display("FAIL no_done_after_reset c=%0d got done=%b v=%b want 0", c, dd_b, dv_b);
            end
        end
        dump_req = 1;
        step();
        dump_req = 0;
        for (int b = 0; b < 32; b++) begin
            #1;
            total++;
            if (dv_b !== 1'b1 || di_b !== b[4:0] || dda_b !== 32'h0) begin
                bad++; $display("FAIL restart_beat b=%0d got v=%b i=%0d d=%h want v=1 i=%0d d=0", b, dv_b, di_b, dda_b, b);
            end
            step();
        end
        #1;
        total++;
        if (dd_b !== 1'b1) begin
            bad++; $display("FAIL restart_done got=%b want=1", dd_b);
        end
        step();
        $display("test_reset_mid_dump: reset at beat 10, restart from idx 0");
    endtask

    initial begin
        test_reset();
        test_write_bypass();
        test_scoreboard();
        test_dump_full();
        test_dump_stall();
        test_reset_mid_dump();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
